// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg
//   Shared definitions for the bit-serial adder:
//   - state_e : controller state encoding (IDLE / RUN / DONE)
//   - cnt_w() : width of the bit counter for a given operand width
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must index bits 0..width-1; keep at least one bit.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// full_adder
//   Single-bit full adder cell.
//   Ports:
//     in1, in2 : operand bits
//     cin      : carry in
//     out      : sum bit
//     cout     : carry out
module full_adder (
  input  logic in1,
  input  logic in2,
  input  logic cin,
  output logic out,
  output logic cout
);

  logic half_sum;

  assign half_sum = in1 ^ in2;
  assign out      = half_sum ^ cin;
  assign cout     = (in1 & in2) | (cin & half_sum);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder: one full_adder cell is reused over WIDTH cycles,
//   LSB first, with the carry held in a flop between cycles.
//   Ports:
//     clk, rst       : clock (rising edge), async active-high reset
//     start          : request, only honoured while idle
//     a, b, cin      : operands, captured when start is accepted
//     busy           : high while an operation is running or completing
//     done           : one-cycle pulse when sum/cout are valid
//     sum, cout      : result, held until the next accepted start
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_out;
  logic fa_cout;

  full_adder u_fa (
    .in1  (a_sh_q[0]),
    .in2  (b_sh_q[0]),
    .cin  (carry_q),
    .out  (fa_out),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Operands drain LSB first; result bits enter at the MSB so that
        // after WIDTH shifts bit 0 of the result sits at sum[0].
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_d   = {fa_out, sum_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_cout;
          cnt_d   = cnt_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
